// File: rtl/valu_pkg.sv
// Shared definitions for the element-wise vector ALU: opcode encoding and
// default geometry constants.
package valu_pkg;

  // Default element width in bits.
  localparam int DATA_WIDTH_DEF = 32;
  // Default number of lanes per vector.
  localparam int ELEMENTS_DEF   = 8;

  // Operation select, applied uniformly to every lane.
  typedef enum logic [3:0] {
    OP_VADD  = 4'b0000,
    OP_VSUB  = 4'b0001,
    OP_VSLL  = 4'b0010,
    OP_VSLT  = 4'b0011,
    OP_VSLTU = 4'b0100,
    OP_VXOR  = 4'b0101,
    OP_VSRL  = 4'b0110,
    OP_VSRA  = 4'b0111,
    OP_VOR   = 4'b1000,
    OP_VAND  = 4'b1001,
    OP_BEQ   = 4'b1010,
    OP_BNE   = 4'b1011,
    OP_BLT   = 4'b1100,
    OP_BGE   = 4'b1101,
    OP_BLTU  = 4'b1110,
    OP_BGEU  = 4'b1111
  } valu_op_e;

endpackage : valu_pkg

// File: rtl/valu_lane.sv
// Single-element combinational integer ALU. One copy per vector lane; lanes
// share nothing, so no carry or flag ever crosses a lane boundary.
module valu_lane
  import valu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  valu_op_e              op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res
);

  // Only the low log2(DATA_WIDTH) bits of b act as the shift amount.
  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt_s;
  logic           lt_signed_s;
  logic           lt_unsigned_s;
  logic           eq_s;

  // Widen a 1-bit compare outcome to a zero-extended lane value.
  function automatic logic [DATA_WIDTH-1:0] flag(input logic f);
    flag = {{(DATA_WIDTH-1){1'b0}}, f};
  endfunction

  assign shamt_s       = b[SHW-1:0];
  assign lt_signed_s   = ($signed(a) < $signed(b));
  assign lt_unsigned_s = (a < b);
  assign eq_s          = (a == b);

  // Opcode decode and result selection for this lane.
  always_comb begin
    res = '0;
    case (op)
      OP_VADD:  res = a + b;
      OP_VSUB:  res = a - b;
      OP_VSLL:  res = a << shamt_s;
      OP_VSLT:  res = flag(lt_signed_s);
      OP_VSLTU: res = flag(lt_unsigned_s);
      OP_VXOR:  res = a ^ b;
      OP_VSRL:  res = a >> shamt_s;
      OP_VSRA:  res = DATA_WIDTH'($signed(a) >>> shamt_s);
      OP_VOR:   res = a | b;
      OP_VAND:  res = a & b;
      OP_BEQ:   res = flag(eq_s);
      OP_BNE:   res = flag(!eq_s);
      OP_BLT:   res = flag(lt_signed_s);
      OP_BGE:   res = flag(!lt_signed_s);
      OP_BLTU:  res = flag(lt_unsigned_s);
      OP_BGEU:  res = flag(!lt_unsigned_s);
      default:  res = '0;
    endcase
  end

endmodule : valu_lane

// File: rtl/valu.sv
// Element-wise vector integer ALU for the execute stage. ELEMENTS lane ALUs
// share one opcode; their results are captured in a single output register
// with a matching valid flop, giving exactly one cycle of latency.
module valu
  import valu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ELEMENTS   = ELEMENTS_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  valu_valid_in,
  input  logic [3:0]            valu_op_in,
  input  logic [DATA_WIDTH-1:0] vrs1_data_in [ELEMENTS],
  input  logic [DATA_WIDTH-1:0] vrs2_data_in [ELEMENTS],
  output logic                  valu_valid_o,
  output logic [DATA_WIDTH-1:0] valu_res_o   [ELEMENTS]
);

  valu_op_e              op_s;
  logic [DATA_WIDTH-1:0] lane_res_s [ELEMENTS];
  logic [DATA_WIDTH-1:0] res_r      [ELEMENTS];
  logic                  valid_r;

  // Every 4-bit code is a defined operation, so the cast is always legal.
  assign op_s = valu_op_e'(valu_op_in);

  for (genvar i = 0; i < ELEMENTS; i++) begin : g_lane
    valu_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .op  (op_s),
      .a   (vrs1_data_in[i]),
      .b   (vrs2_data_in[i]),
      .res (lane_res_s[i])
    );
  end

  // Valid strobe: high for exactly the cycle after a valid input is sampled.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valu_valid_in;
    end
  end

  // Result register: loads on valid input, otherwise holds the last result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < ELEMENTS; i++) begin
        res_r[i] <= '0;
      end
    end else if (valu_valid_in) begin
      for (int i = 0; i < ELEMENTS; i++) begin
        res_r[i] <= lane_res_s[i];
      end
    end else begin
      for (int i = 0; i < ELEMENTS; i++) begin
        res_r[i] <= res_r[i];
      end
    end
  end

  assign valu_valid_o = valid_r;
  assign valu_res_o   = res_r;

endmodule : valu

// File: tb/tb_valu.sv
// Scoreboard bench for valu: directed vectors push expected lane values into
// a queue; a monitor pops and compares whenever the DUT raises its valid.
module tb_valu;
  import valu_pkg::*;

  localparam int DW = 32;
  localparam int NE = 8;

  typedef logic [DW-1:0] vec_t [NE];

  typedef struct {
    string name;
    vec_t  exp;
    int    cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [3:0] op_in;
  vec_t       vrs1;
  vec_t       vrs2;
  logic       valid_o;
  vec_t       res;

  exp_t q[$];
  int   checks;
  int   errors;
  int   cyc;

  valu #(
    .DATA_WIDTH (DW),
    .ELEMENTS   (NE)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .valu_valid_in (valid_in),
    .valu_op_in    (op_in),
    .vrs1_data_in  (vrs1),
    .vrs2_data_in  (vrs2),
    .valu_valid_o  (valid_o),
    .valu_res_o    (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to check the one-cycle latency.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t bc(input logic [DW-1:0] x);
    vec_t v;
    for (int i = 0; i < NE; i++) v[i] = x;
    return v;
  endfunction

  function automatic vec_t seq(input int mul, input int pw);
    vec_t v;
    for (int i = 0; i < NE; i++) v[i] = DW'(mul * (i + 1) ** pw);
    return v;
  endfunction

  // Monitor: pop one expectation per valid result and compare every lane.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got valid with lane0=%h, required no result", res[0]);
      end else begin
        exp_t e;
        int   bad;
        e   = q.pop_front();
        bad = -1;
        for (int i = 0; i < NE; i++) begin
          if (bad < 0 && res[i] !== e.exp[i]) bad = i;
        end
        if (bad >= 0) begin
          errors++;
          $display("FAIL %s: lane %0d got %h required %h", e.name, bad, res[bad], e.exp[bad]);
        end else if (cyc != e.cyc + 1) begin
          errors++;
          $display("FAIL %s_latency: got %0d cycles required 1", e.name, cyc - e.cyc);
        end
      end
    end
  end

  task automatic issue(input valu_op_e op, input vec_t a, input vec_t b,
                       input vec_t e, input string nm);
    exp_t x;
    valid_in = 1'b1;
    op_in    = op;
    vrs1     = a;
    vrs2     = b;
    x.name   = nm;
    x.exp    = e;
    x.cyc    = cyc;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    int bad;
    bad = -1;
    for (int i = 0; i < NE; i++) if (bad < 0 && res[i] !== '0) bad = i;
    checks++;
    if (valid_o !== 1'b0 || bad >= 0) begin
      errors++;
      $display("FAIL %s: got valid=%b bad_lane=%0d, required valid=0 all lanes 0", nm, valid_o, bad);
    end
  endtask

  initial begin
    vec_t s, z, one, neg, msb, hold_exp;
    int   bad;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    op_in    = 4'b0000;
    vrs1     = bc(32'h0);
    vrs2     = bc(32'h0);
    s   = seq(1, 1);
    z   = bc(32'h0);
    one = bc(32'h1);
    neg = bc(32'hFFFF_FFFF);
    msb = bc(32'h8000_0000);

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic arithmetic on {1..8}.
    issue(OP_VADD, s, s, seq(2, 1), "vadd_seq");
    issue(OP_VSUB, s, s, z, "vsub_seq");
    issue(OP_VSLL, s, s,
          '{32'd2, 32'd8, 32'd24, 32'd64, 32'd160, 32'd384, 32'd896, 32'd2048}, "vsll_seq");

    // Compares with equal operands.
    issue(OP_VSLT,  s, s, z,   "vslt_eq");
    issue(OP_VSLTU, s, s, z,   "vsltu_eq");
    issue(OP_BNE,   s, s, z,   "bne_eq");
    issue(OP_BLT,   s, s, z,   "blt_eq");
    issue(OP_BLTU,  s, s, z,   "bltu_eq");
    issue(OP_BEQ,   s, s, one, "beq_eq");
    issue(OP_BGE,   s, s, one, "bge_eq");
    issue(OP_BGEU,  s, s, one, "bgeu_eq");
    issue(OP_VXOR,  s, s, z,   "vxor_eq");
    issue(OP_VOR,   s, s, s,   "vor_eq");
    issue(OP_VAND,  s, s, s,   "vand_eq");

    // Signed versus unsigned with a = -1, b = 1.
    issue(OP_VSLT,  neg, one, one, "vslt_neg");
    issue(OP_VSLTU, neg, one, z,   "vsltu_neg");
    issue(OP_BLT,   neg, one, one, "blt_neg");
    issue(OP_BGEU,  neg, one, one, "bgeu_neg");
    issue(OP_BGE,   neg, one, z,   "bge_neg");
    issue(OP_BLTU,  neg, one, z,   "bltu_neg");
    issue(OP_VADD,  neg, one, z,   "vadd_wrap");

    // Shifts, including a shift amount with ignored upper bits.
    issue(OP_VSRA, msb, bc(32'd4),  bc(32'hF800_0000), "vsra_4");
    issue(OP_VSRL, msb, bc(32'd4),  bc(32'h0800_0000), "vsrl_4");
    issue(OP_VSRA, msb, bc(32'd36), bc(32'hF800_0000), "vsra_36");
    issue(OP_VSRL, msb, bc(32'd36), bc(32'h0800_0000), "vsrl_36");
    issue(OP_VSLL, one, bc(32'd36), bc(32'h0000_0010), "vsll_36");
    idle();

    // Back-to-back VADD then VSUB, then an idle cycle must hold VSUB.
    hold_exp = '{32'd9, 32'd18, 32'd27, 32'd36, 32'd45, 32'd54, 32'd63, 32'd72};
    issue(OP_VADD, seq(10, 1), s, seq(11, 1), "b2b_vadd");
    issue(OP_VSUB, seq(10, 1), s, hold_exp, "b2b_vsub");
    idle();
    bad = -1;
    for (int i = 0; i < NE; i++) if (bad < 0 && res[i] !== hold_exp[i]) bad = i;
    checks++;
    if (valid_o !== 1'b0 || bad >= 0) begin
      errors++;
      $display("FAIL idle_hold: got valid=%b bad_lane=%0d, required valid=0 and VSUB result held",
               valid_o, bad);
    end

    // Asynchronous reset while a fresh result is on the output.
    issue(OP_VADD, s, s, seq(2, 1), "pre_reset");
    rst_n = 1'b0;
    #1;
    check_zero("reset_midstream");
    q.delete();
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_zero("after_reset_idle");

    issue(OP_VOR, s, bc(32'h100), '{32'h101, 32'h102, 32'h103, 32'h104,
                                     32'h105, 32'h106, 32'h107, 32'h108}, "vor_post_reset");
    idle();
    idle();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_valu
